// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: assembles a streamed NUM_PIX-pixel frame plus the bias element into a flat bus,
// fires every neuron once and holds the bus until all neurons report done. PFL_WATCHDOG_EN adds a WAIT watchdog.
module pixel_frame_loader #(
    parameter int               NUM_PIX     = 784,
    parameter int               PIX_W       = 10,
    parameter int               NUM_NEURONS = 10,
    parameter logic [PIX_W-1:0] BIAS_VAL    = 10'd1,
    parameter int               TIMEOUT     = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [PIX_W-1:0]             s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [(NUM_PIX+1)*PIX_W-1:0] pixel,
    output logic                         in_valid,
    input  logic [NUM_NEURONS-1:0]       done_vec,
    output logic                         busy,
    output logic                         frame_err,
    output logic [15:0]                  frame_cnt,
    output logic                         timeout
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        FIRE  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(NUM_PIX - 1);

    state_t                 state_r;
    logic [9:0]             idx_r;
    logic [NUM_NEURONS-1:0] mask_r;
    logic                   in_valid_r;
    logic                   frame_err_r;
    logic                   timeout_r;
    logic [15:0]            frame_cnt_r;
    logic [PIX_W-1:0]       pix_r [NUM_PIX];
    logic                   beat_s;
    logic                   mask_full_s;
`ifdef PFL_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0]            wd_cnt_r;
`endif

    // The index register is 10 bits wide and the watchdog counter 16 bits wide.
    if (NUM_PIX < 2 || NUM_PIX > 1024 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("pixel_frame_loader: NUM_PIX or TIMEOUT out of supported range");
    end

    assign beat_s      = s_valid && s_ready;
    assign mask_full_s = &(mask_r | done_vec);
    assign s_ready     = (state_r == LOAD) || (state_r == DRAIN);
    assign busy        = (state_r == FIRE) || (state_r == WAIT);
    assign in_valid    = in_valid_r;
    assign frame_err   = frame_err_r;
    assign frame_cnt   = frame_cnt_r;
    assign timeout     = timeout_r;

    for (genvar g = 0; g < NUM_PIX; g++) begin : g_bus
        assign pixel[PIX_W*g +: PIX_W] = pix_r[g];
    end
    assign pixel[PIX_W*NUM_PIX +: PIX_W] = BIAS_VAL;

    // Pixel store: written only by accepted LOAD beats, so the bus is frozen from FIRE through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIX; i++) begin
                pix_r[i] <= '0;
            end
        end else if (beat_s && (state_r == LOAD)) begin
            pix_r[idx_r] <= s_data;
        end
    end

    // Frame sequencing: beat framing, fire pulse, done-mask collection and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LOAD;
            idx_r       <= 10'd0;
            mask_r      <= '0;
            in_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            timeout_r   <= 1'b0;
            frame_cnt_r <= 16'd0;
`ifdef PFL_WATCHDOG_EN
            wd_cnt_r    <= 16'd0;
`endif
        end else begin
            in_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            timeout_r   <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (beat_s) begin
                        if (idx_r == LAST_IDX) begin
                            idx_r <= 10'd0;
                            if (s_last) begin
                                state_r    <= FIRE;
                                in_valid_r <= 1'b1;
                            end else begin
                                state_r     <= DRAIN;
                                frame_err_r <= 1'b1;
                            end
                        end else if (s_last) begin
                            idx_r       <= 10'd0;
                            frame_err_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat_s && s_last) begin
                        state_r <= LOAD;
                        idx_r   <= 10'd0;
                    end
                end
                FIRE: begin
                    state_r     <= WAIT;
                    mask_r      <= '0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
`ifdef PFL_WATCHDOG_EN
                    wd_cnt_r    <= 16'd0;
`endif
                end
                WAIT: begin
                    mask_r <= mask_r | done_vec;
`ifdef PFL_WATCHDOG_EN
                    wd_cnt_r <= wd_cnt_r + 16'd1;
`endif
                    if (mask_full_s) begin
                        state_r <= LOAD;
                        idx_r   <= 10'd0;
                    end
`ifdef PFL_WATCHDOG_EN
                    else if (wd_cnt_r == WD_LAST) begin
                        state_r   <= LOAD;
                        idx_r     <= 10'd0;
                        timeout_r <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_r <= LOAD;
                    idx_r   <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Bench for pixel_frame_loader: a table of frame shapes plus hand-written done/reset/watchdog sequences;
// every in_valid pops the scoreboard and compares frame_cnt and the whole pixel bus.
`timescale 1ns/1ps
module tb_pixel_frame_loader;
    localparam int NUM_PIX    = 784;
    localparam int PIX_W      = 10;
    localparam int NN         = 10;
    localparam int BW         = (NUM_PIX + 1) * PIX_W;
    localparam int TB_TIMEOUT = 50;
    localparam int STAG [NN]  = '{5, 5, 7, 10, 13, 16, 19, 22, 25, 30};

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             s_valid  = 1'b0;
    logic [PIX_W-1:0] s_data   = '0;
    logic             s_last   = 1'b0;
    logic [NN-1:0]    done_vec = '0;
    logic             s_ready;
    logic [BW-1:0]    pixel;
    logic             in_valid;
    logic             busy;
    logic             frame_err;
    logic [15:0]      frame_cnt;
    logic             timeout;

    always #5 clk = ~clk;

    pixel_frame_loader #(
        .NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .NUM_NEURONS(NN), .BIAS_VAL(10'd1), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .pixel(pixel), .in_valid(in_valid), .done_vec(done_vec), .busy(busy), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .timeout(timeout)
    );

    typedef struct {
        string name;
        int    n;
        int    last_at;
        int    base;
        int    exp_err;
        int    exp_fire;
    } vec_t;

    typedef struct {
        logic [BW-1:0] bus;
        logic [15:0]   cnt;
    } sb_t;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               n_fire = 0;
    int               n_err = 0;
    int               n_to = 0;
    int               fire_cyc = -1;
    int               last_beat_cyc = 0;
    sb_t              sb_q [$];
    sb_t              sb_e;
    logic [PIX_W-1:0] exp_pix [NUM_PIX];
    int               m_idx;
    bit               m_drain;
    logic [15:0]      m_cnt;
    logic [NN-1:0]    sched [1:40];
    vec_t             tbl [5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < NUM_PIX; i++) b[PIX_W*i +: PIX_W] = exp_pix[i];
        b[PIX_W*NUM_PIX +: PIX_W] = 10'd1;
        return b;
    endfunction

    function automatic int bus_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int n = 0;
        for (int i = 0; i <= NUM_PIX; i++) if (a[PIX_W*i +: PIX_W] !== b[PIX_W*i +: PIX_W]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_PIX; i++) exp_pix[i] = '0;
        m_idx = 0;
        m_drain = 1'b0;
        m_cnt = 16'd0;
    endtask

    // Reference framing model: one call per beat accepted at a rising edge.
    task automatic model_beat(input logic [PIX_W-1:0] d, input logic last);
        if (m_drain) begin
            if (last) m_drain = 1'b0;
        end else begin
            exp_pix[m_idx] = d;
            if (m_idx == NUM_PIX - 1) begin
                m_idx = 0;
                if (last) begin
                    sb_q.push_back('{bus: model_bus(), cnt: m_cnt});
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_drain = 1'b1;
                end
            end else if (last) begin
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic send_beats(input int n, input int last_at, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = PIX_W'((base + i) % 1024);
            s_last  = (i == last_at);
            if (i == 0) check("s_ready_first_beat", 64'(s_ready), 64'd1);
            @(posedge clk);
            model_beat(s_data, s_last);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        last_beat_cyc = cyc;
    endtask

    task automatic clear_sched();
        for (int c = 1; c <= 40; c++) sched[c] = '0;
    endtask

    // Plays sched[1..ncyc] on done_vec from WAIT cycle 1; the mask must complete in cycle 'finish'.
    task automatic play_sched(input int ncyc, input int finish);
        int bad = 0;
        for (int c = 1; c <= ncyc; c++) begin
            done_vec = sched[c];
            if (c <= finish && (busy !== 1'b1 || s_ready !== 1'b0)) bad++;
            @(posedge clk);
            #1;
        end
        done_vec = '0;
        check("busy_held_in_wait", 64'(bad), 64'd0);
        check("s_ready_after_done", 64'(s_ready), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string name);
        logic [PIX_W-1:0] bias;
        bias = pixel[PIX_W*NUM_PIX +: PIX_W];
        check({name, "_s_ready"}, 64'(s_ready), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_in_valid"}, 64'(in_valid), 64'd0);
        check({name, "_frame_err"}, 64'(frame_err), 64'd0);
        check({name, "_timeout"}, 64'(timeout), 64'd0);
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({name, "_bus_zero"}, 64'(bus_diff(pixel, model_bus())), 64'd0);
        check({name, "_bias"}, 64'(bias), 64'd1);
    endtask

    task automatic run_entry(input vec_t v);
        int e0 = n_err;
        int f0 = n_fire;
        send_beats(v.n, v.last_at, v.base);
        if (v.exp_fire != 0) begin
            check({v.name, "_in_valid_fire"}, 64'(in_valid), 64'd1);
            @(posedge clk);
            #1;
            clear_sched();
            sched[1] = '1;
            play_sched(1, 1);
            check({v.name, "_fire_latency"}, 64'(fire_cyc), 64'(last_beat_cyc));
        end else begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
        check({v.name, "_frame_err_pulses"}, 64'(n_err - e0), 64'(v.exp_err));
        check({v.name, "_in_valid_pulses"}, 64'(n_fire - f0), 64'(v.exp_fire));
        check({v.name, "_frame_cnt"}, 64'(frame_cnt), 64'(m_cnt));
    endtask

    // Output monitor on the falling edge: pulse counters and the fire scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (in_valid === 1'b1) begin
                n_fire++;
                fire_cyc = cyc;
                check("sb_pending_at_fire", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    check("frame_cnt_at_fire", 64'(frame_cnt), 64'(sb_e.cnt));
                    check("pixel_bus_at_fire", 64'(bus_diff(pixel, sb_e.bus)), 64'd0);
                end
            end
            if (frame_err === 1'b1) n_err++;
            if (timeout === 1'b1) n_to++;
        end
    end

    initial begin
        int t0;
        tbl[0] = '{"ramp",        NUM_PIX,     NUM_PIX - 1, 0,   0, 1};
        tbl[1] = '{"short",       100,         99,          600, 1, 0};
        tbl[2] = '{"after_short", NUM_PIX,     NUM_PIX - 1, 300, 0, 1};
        tbl[3] = '{"no_last",     NUM_PIX + 5, NUM_PIX + 4, 40,  1, 0};
        tbl[4] = '{"after_drain", NUM_PIX,     NUM_PIX - 1, 777, 0, 1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("por");

        for (int k = 0; k < 5; k++) run_entry(tbl[k]);

        // Done pulses while loading are ignored, then staggered completion with repeats on neuron 3.
        done_vec = '1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        done_vec = '0;
        check("load_done_s_ready", 64'(s_ready), 64'd1);
        check("load_done_busy", 64'(busy), 64'd0);
        send_beats(NUM_PIX, NUM_PIX - 1, 123);
        @(posedge clk);
        #1;
        clear_sched();
        for (int k = 0; k < NN; k++) sched[STAG[k]][k] = 1'b1;
        sched[11][3] = 1'b1;
        sched[12][3] = 1'b1;
        play_sched(30, 30);
        check("stagger_frame_cnt", 64'(frame_cnt), 64'(m_cnt));

        // Reset in WAIT after four neurons have answered.
        send_beats(NUM_PIX, NUM_PIX - 1, 500);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            done_vec = NN'(1 << k);
            @(posedge clk);
            #1;
        end
        done_vec = '0;
        check("busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_reset_state("midwait");
        run_entry(tbl[0]);

        // Done during FIRE is ignored and only nine neurons answer.
        send_beats(NUM_PIX, NUM_PIX - 1, 900);
        done_vec = '1;
        @(posedge clk);
        #1;
        t0 = n_to;
`ifdef PFL_WATCHDOG_EN
        begin
            int to_at = 0;
            int rdy_at = 0;
            for (int c = 1; c <= TB_TIMEOUT + 10; c++) begin
                done_vec = (c == 1) ? 10'h1FF : 10'h000;
                @(posedge clk);
                #1;
                if (timeout === 1'b1 && to_at == 0) begin
                    to_at = c + 1;
                    rdy_at = int'(s_ready);
                end
            end
            check("timeout_cycle", 64'(to_at), 64'(TB_TIMEOUT + 1));
            check("timeout_s_ready", 64'(rdy_at), 64'd1);
            check("timeout_pulses", 64'(n_to - t0), 64'd1);
            check("timeout_frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        end
`else
        for (int c = 1; c <= 1100; c++) begin
            done_vec = (c == 1) ? 10'h1FF : 10'h000;
            @(posedge clk);
            #1;
        end
        check("stuck_busy", 64'(busy), 64'd1);
        check("stuck_s_ready", 64'(s_ready), 64'd0);
        check("no_timeout_pulse", 64'(n_to - t0), 64'd0);
        done_vec = 10'h200;
        @(posedge clk);
        #1;
        done_vec = '0;
        check("late_done_busy", 64'(busy), 64'd0);
        check("late_done_s_ready", 64'(s_ready), 64'd1);
`endif
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_loader.md
# pixel_frame_loader

Serial-to-parallel front end for the digit classifier. Accepts one 28×28 image as a stream of 10-bit fixed-point pixels over a valid/ready handshake and assembles the flat pixel bus consumed by the ten neuron-sum blocks. It appends the constant bias element and fires a single-cycle start pulse. It then holds the bus stable until every neuron has returned its own one-cycle done pulse, and only then accepts the next frame.

## Interface
- NUM_PIX, 784: streamed pixels per frame; the bus carries NUM_PIX+1 elements.
- PIX_W, 10: pixel width in bits.
- NUM_NEURONS, 10: number of neuron-sum blocks driven in parallel.
- BIAS_VAL, 10'd1: constant placed in element NUM_PIX, the bias input.
- TIMEOUT, 1023: watchdog limit in cycles; used only with PFL_WATCHDOG_EN.

- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- s_valid, in, 1: pixel beat valid.
- s_data, in, PIX_W: pixel value.
- s_last, in, 1: marks the final beat of a frame.
- s_ready, out, 1: loader can accept a beat.
- pixel, out, (NUM_PIX+1)*PIX_W: flat bus; element i at [PIX_W*i +: PIX_W].
- in_valid, out, 1: one-cycle start pulse to all neurons.
- done_vec, in, NUM_NEURONS: per-neuron one-cycle result-valid pulses.
- busy, out, 1: frame is in flight (FIRE or WAIT).
- frame_err, out, 1: one-cycle pulse on a framing error.
- frame_cnt, out, 16: count of fired frames; wraps from 0xFFFF to 0.
- timeout, out, 1: one-cycle watchdog pulse; tied 0 without the macro.

## Operation
- States: LOAD, DRAIN, FIRE, WAIT. The state is LOAD after reset.
- Beat acceptance: a beat is accepted when s_valid && s_ready at a rising edge.
- s_ready = (state==LOAD) || (state==DRAIN). It is combinational from state.
- LOAD:
  - An accepted beat writes s_data to element idx, then idx increments. idx is 10-bit and runs 0..NUM_PIX-1.
  - Beat with idx==NUM_PIX-1 and s_last=1: go to FIRE, reset idx to 0.
  - Beat with idx==NUM_PIX-1 and s_last=0: pulse frame_err, go to DRAIN.
  - Beat with idx<NUM_PIX-1 and s_last=1 (short frame): pulse frame_err, reset idx to 0, stay in LOAD.
  - Partially written elements are not cleared; they are overwritten by the next frame.
- DRAIN: discard beats. An accepted beat with s_last=1 returns the block to LOAD with idx=0. No error pulse is issued on exit.
- FIRE: lasts exactly one cycle.
  - in_valid=1 during this cycle.
  - frame_cnt increments on the edge that leaves FIRE.
  - Next state is WAIT and the done mask clears.
- WAIT:
  - mask <= mask | done_vec on each edge.
  - When (mask | done_vec) is all ones, go to LOAD.
  - Repeated done pulses from the same neuron are harmless.
  - done_vec is ignored in every other state.
- Bus rules:
  - Element NUM_PIX is always BIAS_VAL, including during reset.
  - The bus changes only on accepted LOAD beats, so it is stable from FIRE through WAIT.
- Reset in any state:
  - Next state is LOAD, idx=0, mask=0, pixel elements 0..NUM_PIX-1 = 0.
  - in_valid=0, frame_err=0, timeout=0, frame_cnt=0.
  - busy=0 and s_ready=1 on the first cycle after rst deasserts.
  - A frame in flight is abandoned and no in_valid is issued for it.

## Timing
- Last beat accepted at edge N: the block is in FIRE and in_valid=1 during cycle N+1; it is in WAIT from edge N+1.
- busy=1 in cycles N+1 onward, until the edge where the mask completes.
- Final done pulse present in cycle M: the block returns to LOAD at edge M. s_ready=1 and busy=0 in cycle M+1.
- Minimum gap between in_valid pulses: NUM_PIX + 2 cycles, counted as the load beats, FIRE, and at least one WAIT cycle.
- Throughput: one beat per cycle in LOAD when s_valid is held high.
- frame_err and timeout are asserted in the cycle after the triggering edge, for one cycle.

## Configuration
- PFL_WATCHDOG_EN defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without a complete mask, pulse timeout and go to LOAD with idx=0.
  - frame_cnt is not rolled back.
- PFL_WATCHDOG_EN undefined:
  - No counter exists and timeout is constant 0.
  - WAIT persists until all done bits have been seen.

## Test plan
- Ramp frame: 784 beats with s_data=i mod 1024 and s_last on the last beat.
  - in_valid rises exactly once, one cycle after the last beat.
  - pixel[10*i +: 10] = i mod 1024, and element 784 = 1.
  - frame_cnt goes 0 -> 1.
  - s_ready=0 until all done bits are seen.
- Staggered done: neurons 0..9 pulse on WAIT cycles 5,5,7,…,30.
  - Return to LOAD exactly one cycle after neuron 9's pulse.
  - A neuron 3 pulse repeated twice has no effect.
  - A done pulse driven during LOAD is ignored.
- Short frame: s_last on beat 100.
  - frame_err pulses once and no in_valid is issued.
  - The following full frame loads correctly with idx starting at 0.
- Missing s_last: 784 beats without s_last, then 5 extra beats with s_last on the 5th.
  - frame_err pulses after beat 784.
  - The 5 extra beats are discarded and the next frame is accepted normally.
- Reset mid-WAIT after 4 of 10 done pulses:
  - Outputs return to reset values and the bus reads all zero except the bias element.
  - A new frame fires normally.
- With PFL_WATCHDOG_EN and TIMEOUT=50: fire a frame, return only 9 done pulses.
  - timeout pulses 50 cycles after entering WAIT and s_ready rises.
  - Without the macro, the block stays busy indefinitely.
